// File: rtl/snn_pkg.sv
// Shared definitions for the fan-in source controller datapath.
package snn_pkg;

  localparam int unsigned ADDR_WIDTH = 14;

  typedef logic [ADDR_WIDTH-1:0] spike_addr_t;

  // Frame-buffer control states, 2-bit encoding
  typedef enum logic [1:0] {
    S_COLLECT   = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2
  } frame_state_t;

endpackage

// File: rtl/spike_fifo_mem.sv
// Storage array for the spike frame buffer: registered write, asynchronous read.
module spike_fifo_mem
  import snn_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = snn_pkg::ADDR_WIDTH,
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [ADDR_WIDTH-1:0] wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [ADDR_WIDTH-1:0] mem [DEPTH];

  // Store an accepted event at the write slot
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/spike_frame_buffer.sv
// Circular FWFT spike buffer that exposes only the most recently closed frame
// to the controller; events arriving during processing wait for the next frame.
module spike_frame_buffer
  import snn_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = snn_pkg::ADDR_WIDTH,
  parameter int unsigned DEPTH_LOG2     = 6,
  parameter int unsigned DROP_CTR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_aer_valid,
  input  logic [ADDR_WIDTH-1:0]     i_aer_addr,
  output logic                      o_aer_ready,
  input  logic                      i_timestep_tick,
  output logic                      o_start_processing,
  input  logic                      i_processing_done,
  input  logic                      i_spike_fifo_rden,
  output logic [ADDR_WIDTH-1:0]     o_spike_fifo_rdata,
  output logic                      o_spike_fifo_empty,
  output logic [DROP_CTR_WIDTH-1:0] o_drop_count,
  output logic                      o_tick_overrun
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;

  frame_state_t state, state_next;

  logic [PW-1:0] wr_ptr, rd_ptr, frame_rem, occ;
  logic          full, empty, wr_en, rd_en, abort, close_frame, overrun_set;

  assign occ   = wr_ptr - rd_ptr;
  assign full  = (occ == PW'(DEPTH));
  assign empty = (frame_rem == '0);
  assign wr_en = i_aer_valid && !full;
  assign rd_en = i_spike_fifo_rden && !empty;
  // An abort skips the read pointer past the leftovers, absorbing any same-cycle pop
  assign abort = (state == S_WAIT_DONE) && i_processing_done && !empty;

  assign o_aer_ready        = !full;
  assign o_spike_fifo_empty = empty;
  assign o_start_processing = (state == S_LAUNCH);

  // Next-state logic: close frames on tick, flag ticks that arrive mid-frame
  always_comb begin
    state_next  = state;
    close_frame = 1'b0;
    overrun_set = 1'b0;
    case (state)
      S_COLLECT: begin
        if (i_timestep_tick) begin
          close_frame = 1'b1;
          state_next  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        overrun_set = i_timestep_tick;
        state_next  = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        overrun_set = i_timestep_tick;
        if (i_processing_done) begin
          state_next = S_COLLECT;
        end
      end
      default: state_next = S_COLLECT;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // Pointer and closed-frame bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      frame_rem <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (abort) begin
        rd_ptr    <= rd_ptr + frame_rem;
        frame_rem <= '0;
      end else if (close_frame) begin
        frame_rem <= occ;
      end else if (rd_en) begin
        rd_ptr    <= rd_ptr + PW'(1);
        frame_rem <= frame_rem - PW'(1);
      end
    end
  end

  // Saturating count of events lost to a full buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      o_drop_count <= '0;
    end else if (i_aer_valid && full && (o_drop_count != '1)) begin
      o_drop_count <= o_drop_count + DROP_CTR_WIDTH'(1);
    end
  end

  // Sticky overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      o_tick_overrun <= 1'b0;
    end else if (overrun_set) begin
      o_tick_overrun <= 1'b1;
    end
  end

  spike_fifo_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
    .wr_data (i_aer_addr),
    .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
    .rd_data (o_spike_fifo_rdata)
  );

endmodule

// File: tb/tb_spike_frame_buffer.sv
// Bench for spike_frame_buffer: directed table, hand sequences, random traffic
// against a queue-based frame model.
module tb_spike_frame_buffer;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst, aer_valid, tick, done, rden;
  logic [AW-1:0] aer_addr;
  logic          ready, start, empty, overrun;
  logic [AW-1:0] rdata;
  logic [15:0]   drop;
  logic          ready2, start2, empty2, overrun2;
  logic [AW-1:0] rdata2;
  logic [1:0]    drop2;

  always #5 clk = ~clk;

  spike_frame_buffer #(
    .ADDR_WIDTH (AW),
    .DEPTH_LOG2 (6),
    .DROP_CTR_WIDTH (16)
  ) dut (
    .clk (clk), .rst (rst),
    .i_aer_valid (aer_valid), .i_aer_addr (aer_addr), .o_aer_ready (ready),
    .i_timestep_tick (tick), .o_start_processing (start),
    .i_processing_done (done), .i_spike_fifo_rden (rden),
    .o_spike_fifo_rdata (rdata), .o_spike_fifo_empty (empty),
    .o_drop_count (drop), .o_tick_overrun (overrun)
  );

  // Same stimulus, narrow drop counter to exercise saturation
  spike_frame_buffer #(
    .ADDR_WIDTH (AW),
    .DEPTH_LOG2 (6),
    .DROP_CTR_WIDTH (2)
  ) dut_sat (
    .clk (clk), .rst (rst),
    .i_aer_valid (aer_valid), .i_aer_addr (aer_addr), .o_aer_ready (ready2),
    .i_timestep_tick (tick), .o_start_processing (start2),
    .i_processing_done (done), .i_spike_fifo_rden (rden),
    .o_spike_fifo_rdata (rdata2), .o_spike_fifo_empty (empty2),
    .o_drop_count (drop2), .o_tick_overrun (overrun2)
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: closed frame and next-frame events as queues
  logic [AW-1:0] closed[$];
  logic [AW-1:0] pending[$];
  int            phase;     // 0 collecting, 1 launching, 2 waiting for done
  int            drops;
  bit            ovr;

  function automatic int cap(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic void model_reset();
    closed.delete();
    pending.delete();
    phase = 0;
    drops = 0;
    ovr   = 1'b0;
  endfunction

  function automatic void model_check();
    bit m_full;
    m_full = (closed.size() + pending.size()) == 64;
    chk("ready", ready, !m_full);
    chk("ready_sat", ready2, !m_full);
    chk("empty", empty, closed.size() == 0);
    chk("start", start, phase == 1);
    chk("overrun", overrun, ovr);
    chk("drop", drop, cap(drops, 65535));
    chk("drop_sat", drop2, cap(drops, 3));
    if (closed.size() != 0) chk("rdata", rdata, closed[0]);
  endfunction

  function automatic void model_step(input logic v, input logic [AW-1:0] a,
                                     input logic t, input logic d, input logic r);
    bit m_full, m_empty, aborted;
    logic [AW-1:0] tmp;
    m_full  = (closed.size() + pending.size()) == 64;
    m_empty = closed.size() == 0;
    aborted = 1'b0;
    case (phase)
      0: if (t) begin
        closed = pending;
        pending.delete();
        phase = 1;
      end
      1: begin
        if (t) ovr = 1'b1;
        phase = 2;
      end
      default: begin
        if (t) ovr = 1'b1;
        if (d) begin
          closed.delete();
          aborted = 1'b1;
          phase = 0;
        end
      end
    endcase
    if (r && !m_empty && !aborted) tmp = closed.pop_front();
    if (v && !m_full) pending.push_back(a);
    else if (v) drops++;
  endfunction

  task automatic drive_cycle(input logic v, input logic [AW-1:0] a,
                             input logic t, input logic d, input logic r);
    aer_valid = v; aer_addr = a; tick = t; done = d; rden = r;
    model_check();
    @(posedge clk);
    model_step(v, a, t, d, r);
    #1;
  endtask

  task automatic rst_cycle();
    rst = 1'b1;
    aer_valid = 1'b0; tick = 1'b0; done = 1'b0; rden = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic          t, d, r;
    logic          e_empty, e_start, e_chk;
    logic [AW-1:0] e_data;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // inputs this cycle, then outputs expected before the edge
    vecs[0]  = '{1'b1, 14'd5,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 14'd0};
    vecs[1]  = '{1'b1, 14'd9,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 14'd0};
    vecs[2]  = '{1'b1, 14'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 14'd0};
    vecs[3]  = '{1'b0, 14'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 14'd0};
    vecs[4]  = '{1'b0, 14'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 14'd5};
    vecs[5]  = '{1'b0, 14'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 14'd5};
    vecs[6]  = '{1'b0, 14'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 14'd9};
    vecs[7]  = '{1'b0, 14'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 14'd12};
    vecs[8]  = '{1'b0, 14'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 14'd0};
    vecs[9]  = '{1'b0, 14'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 14'd0};
    vecs[10] = '{1'b1, 14'd21, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 14'd0};
    vecs[11] = '{1'b0, 14'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 14'd0};
    vecs[12] = '{1'b0, 14'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 14'd21};

    aer_addr = '0;
    #2;
    rst_cycle();

    // Reset state; rden while empty is harmless
    chk("rst_empty", empty, 1);
    chk("rst_ready", ready, 1);
    chk("rst_start", start, 0);
    chk("rst_drop", drop, 0);
    chk("rst_overrun", overrun, 0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("rden_empty", empty, 1);
    chk("rden_ready", ready, 1);

    // Directed frame: 5,9,12 then tick, pops, ignored extra rden
    for (int i = 0; i < 13; i++) begin
      aer_valid = vecs[i].v; aer_addr = vecs[i].a; tick = vecs[i].t;
      done = vecs[i].d; rden = vecs[i].r;
      chk($sformatf("vec%0d_empty", i), empty, vecs[i].e_empty);
      chk($sformatf("vec%0d_start", i), start, vecs[i].e_start);
      if (vecs[i].e_chk) chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].e_data);
      drive_cycle(vecs[i].v, vecs[i].a, vecs[i].t, vecs[i].d, vecs[i].r);
    end

    // Events during processing belong to the next frame
    rst_cycle();
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("empty_frame_start", start, 1);
    chk("empty_frame_empty", empty, 1);
    drive_cycle(1'b1, 14'd7, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 14'd8, 1'b0, 1'b0, 1'b0);
    chk("held_empty", empty, 1);
    drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    drive_cycle(1'b1, 14'd3, 1'b1, 1'b0, 1'b0);
    chk("frame2_head", rdata, 7);
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("frame2_second", rdata, 8);
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("frame2_done_empty", empty, 1);
    drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("frame3_head", rdata, 3);
    chk("frame3_empty", empty, 0);
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Fill to full, then drops with saturation
    rst_cycle();
    for (int i = 0; i < 64; i++) drive_cycle(1'b1, AW'(100 + i), 1'b0, 1'b0, 1'b0);
    chk("full_ready", ready, 0);
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 14'h3fff, 1'b0, 1'b0, i == 4);
    chk("drop_wide", drop, 5);
    chk("drop_narrow", drop2, 3);
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("full_head", rdata, 100);
    for (int i = 0; i < 64; i++) drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("full_drained", empty, 1);
    drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Overrun: second tick while frame in flight
    rst_cycle();
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("ovr_start", start, 1);
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("ovr_flag", overrun, 1);
    chk("ovr_nostart", start, 0);
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("ovr_nostart2", start, 0);

    // Abort discards leftovers; reset mid-frame clears everything
    rst_cycle();
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, AW'(40 + i), 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("abort_pre", rdata, 42);
    drive_cycle(1'b1, 14'd50, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("abort_empty", empty, 1);
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("abort_next_head", rdata, 50);
    drive_cycle(1'b1, 14'd60, 1'b0, 1'b0, 1'b0);
    rst_cycle();
    chk("midrst_empty", empty, 1);
    chk("midrst_ready", ready, 1);
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("midrst_frame_empty", empty, 1);
    chk("midrst_start", start, 1);

    // Random traffic against the model
    for (int blk = 0; blk < 8; blk++) begin
      int unsigned vp;
      vp = (blk % 2 == 0) ? 95 : 50;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(399) == 0) rst_cycle();
        else drive_cycle($urandom_range(99) < vp, AW'($urandom),
                         $urandom_range(99) < 4, $urandom_range(99) < 8,
                         $urandom_range(99) < 60);
      end
    end
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
